// File: rtl/bsg_manycore_ver_chain_stitch.sv
// rtl/bsg_manycore_ver_chain_stitch.sv - elastic, runtime-bypassable vertical stitch for a tile column
// One FIFO per hop in each direction; bypassed nodes splice adjacent FIFOs together.

module bsg_manycore_ver_chain_stitch_fifo #(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);
    localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W = $clog2(els_p + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(els_p);

    logic [width_p-1:0] mem_q [els_p];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               enq, deq;

    assign ready_o = (cnt_q != FULL_CNT);
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = v_o & ready_i;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module bsg_manycore_ver_chain_stitch #(
    parameter int num_nodes_p = 2,
    parameter int width_p     = 64,
    parameter int els_p       = 2
) (
    input  logic                             mc_clk_i,
    input  logic                             mc_reset_n_i,
    input  logic                             ext_n_v_i,
    input  logic [width_p-1:0]               ext_n_data_i,
    output logic                             ext_n_ready_o,
    output logic                             ext_s_v_o,
    output logic [width_p-1:0]               ext_s_data_o,
    input  logic                             ext_s_ready_i,
    input  logic                             ext_s_v_i,
    input  logic [width_p-1:0]               ext_s_data_i,
    output logic                             ext_s_ready_o,
    output logic                             ext_n_v_o,
    output logic [width_p-1:0]               ext_n_data_o,
    input  logic                             ext_n_ready_i,
    output logic [num_nodes_p-1:0]           node_sb_v_o,
    output logic [num_nodes_p*width_p-1:0]   node_sb_data_o,
    input  logic [num_nodes_p-1:0]           node_sb_ready_i,
    input  logic [num_nodes_p-1:0]           node_sb_v_i,
    input  logic [num_nodes_p*width_p-1:0]   node_sb_data_i,
    output logic [num_nodes_p-1:0]           node_sb_ready_o,
    output logic [num_nodes_p-1:0]           node_nb_v_o,
    output logic [num_nodes_p*width_p-1:0]   node_nb_data_o,
    input  logic [num_nodes_p-1:0]           node_nb_ready_i,
    input  logic [num_nodes_p-1:0]           node_nb_v_i,
    input  logic [num_nodes_p*width_p-1:0]   node_nb_data_i,
    output logic [num_nodes_p-1:0]           node_nb_ready_o,
    input  logic [num_nodes_p-1:0]           node_idle_i,
    input  logic                             cfg_v_i,
    input  logic [num_nodes_p-1:0]           cfg_bypass_i,
    output logic                             cfg_ready_o,
    output logic                             cfg_done_o,
    output logic [num_nodes_p-1:0]           bypass_o
);
    localparam int N = num_nodes_p;

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_APPLY} state_e;

    state_e         state_q;
    logic [N-1:0]   pending_q, bypass_q;
    logic           cfg_done_q, cfg_ready_q;
    logic           drained;

    logic [N:0]              sb_enq_v, sb_enq_ready, sb_deq_v, sb_deq_ready;
    logic [N:0][width_p-1:0] sb_enq_data, sb_deq_data;
    logic [N:0]              nb_enq_v, nb_enq_ready, nb_deq_v, nb_deq_ready;
    logic [N:0][width_p-1:0] nb_enq_data, nb_deq_data;

    assign drained     = ~|sb_deq_v & ~|nb_deq_v & (&node_idle_i);
    assign cfg_ready_o = cfg_ready_q;
    assign cfg_done_o  = cfg_done_q;
    assign bypass_o    = bypass_q;

    // cfg_ready_q doubles as the ingress gate: external traffic only enters while IDLE.
    always_ff @(posedge mc_clk_i or negedge mc_reset_n_i) begin
        if (!mc_reset_n_i) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            bypass_q    <= '0;
            cfg_done_q  <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (cfg_v_i) begin
                    pending_q   <= cfg_bypass_i;
                    cfg_ready_q <= 1'b0;
                    state_q     <= ST_DRAIN;
                end
                ST_DRAIN: if (drained) begin
                    cfg_done_q <= 1'b1;
                    state_q    <= ST_APPLY;
                end
                ST_APPLY: begin
                    bypass_q    <= pending_q;
                    cfg_done_q  <= 1'b0;
                    cfg_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ext_n_ready_o = sb_enq_ready[0] & cfg_ready_q;
    assign ext_s_ready_o = nb_enq_ready[N] & cfg_ready_q;

    for (genvar k = 0; k <= N; k++) begin : g_seg
        bsg_manycore_ver_chain_stitch_fifo #(.width_p(width_p), .els_p(els_p)) u_sb_fifo (
            .clk_i(mc_clk_i), .rst_n_i(mc_reset_n_i),
            .v_i(sb_enq_v[k]), .data_i(sb_enq_data[k]), .ready_o(sb_enq_ready[k]),
            .v_o(sb_deq_v[k]), .data_o(sb_deq_data[k]), .ready_i(sb_deq_ready[k])
        );
        bsg_manycore_ver_chain_stitch_fifo #(.width_p(width_p), .els_p(els_p)) u_nb_fifo (
            .clk_i(mc_clk_i), .rst_n_i(mc_reset_n_i),
            .v_i(nb_enq_v[k]), .data_i(nb_enq_data[k]), .ready_o(nb_enq_ready[k]),
            .v_o(nb_deq_v[k]), .data_o(nb_deq_data[k]), .ready_i(nb_deq_ready[k])
        );

        // Southbound: fed from ext N or node k-1 (or straight from segment k-1 when node k-1 is bypassed).
        if (k == 0) begin : g_sb_src_ext
            assign sb_enq_v[k]    = ext_n_v_i & cfg_ready_q;
            assign sb_enq_data[k] = ext_n_data_i;
        end else begin : g_sb_src_node
            assign sb_enq_v[k]    = bypass_q[k-1] ? sb_deq_v[k-1] : node_sb_v_i[k-1];
            assign sb_enq_data[k] = bypass_q[k-1] ? sb_deq_data[k-1]
                                                  : node_sb_data_i[(k-1)*width_p +: width_p];
        end

        if (k == N) begin : g_sb_dst_ext
            assign ext_s_v_o       = sb_deq_v[k];
            assign ext_s_data_o    = sb_deq_data[k];
            assign sb_deq_ready[k] = ext_s_ready_i;
        end else begin : g_sb_dst_node
            assign node_sb_v_o[k]                        = sb_deq_v[k] & ~bypass_q[k];
            assign node_sb_data_o[k*width_p +: width_p]  = sb_deq_data[k];
            assign sb_deq_ready[k] = bypass_q[k] ? sb_enq_ready[k+1] : node_sb_ready_i[k];
        end

        // Northbound mirrors the above with the chain reversed.
        if (k == N) begin : g_nb_src_ext
            assign nb_enq_v[k]    = ext_s_v_i & cfg_ready_q;
            assign nb_enq_data[k] = ext_s_data_i;
        end else begin : g_nb_src_node
            assign nb_enq_v[k]    = bypass_q[k] ? nb_deq_v[k+1] : node_nb_v_i[k];
            assign nb_enq_data[k] = bypass_q[k] ? nb_deq_data[k+1]
                                                : node_nb_data_i[k*width_p +: width_p];
        end

        if (k == 0) begin : g_nb_dst_ext
            assign ext_n_v_o       = nb_deq_v[k];
            assign ext_n_data_o    = nb_deq_data[k];
            assign nb_deq_ready[k] = ext_n_ready_i;
        end else begin : g_nb_dst_node
            assign node_nb_v_o[k-1]                          = nb_deq_v[k] & ~bypass_q[k-1];
            assign node_nb_data_o[(k-1)*width_p +: width_p]  = nb_deq_data[k];
            assign nb_deq_ready[k] = bypass_q[k-1] ? nb_enq_ready[k-1] : node_nb_ready_i[k-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_node_ready
        assign node_sb_ready_o[i] = ~bypass_q[i] & sb_enq_ready[i+1];
        assign node_nb_ready_o[i] = ~bypass_q[i] & nb_enq_ready[i];
    end
endmodule

// File: tb/tb_bsg_manycore_ver_chain_stitch.sv
// tb/tb_bsg_manycore_ver_chain_stitch.sv - directed self-checking bench for the vertical chain stitch

module tb_bsg_manycore_ver_chain_stitch;
    localparam int N = 2;
    localparam int W = 16;
    localparam int E = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         ext_n_v_i, ext_n_ready_o, ext_s_v_o, ext_s_ready_i;
    logic         ext_s_v_i, ext_s_ready_o, ext_n_v_o, ext_n_ready_i;
    logic [W-1:0] ext_n_data_i, ext_s_data_o, ext_s_data_i, ext_n_data_o;
    logic [N-1:0]   node_sb_v_o, node_sb_ready_i, node_sb_v_i, node_sb_ready_o;
    logic [N-1:0]   node_nb_v_o, node_nb_ready_i, node_nb_v_i, node_nb_ready_o;
    logic [N*W-1:0] node_sb_data_o, node_sb_data_i, node_nb_data_o, node_nb_data_i;
    logic [N-1:0]   node_idle_i, cfg_bypass_i, bypass_o;
    logic           cfg_v_i, cfg_ready_o, cfg_done_o;

    logic         d1_ext_n_v_i, d1_ext_n_ready_o, d1_ext_s_v_o, d1_ext_s_ready_i;
    logic         d1_ext_s_v_i, d1_ext_s_ready_o, d1_ext_n_v_o, d1_ext_n_ready_i;
    logic [W-1:0] d1_ext_n_data_i, d1_ext_s_data_o, d1_ext_s_data_i, d1_ext_n_data_o;
    logic [0:0]   d1_node_sb_v_o, d1_node_sb_ready_o, d1_node_nb_v_o, d1_node_nb_ready_o;
    logic [W-1:0] d1_node_sb_data_o, d1_node_nb_data_o;
    logic [0:0]   d1_cfg_bypass_i, d1_bypass_o;
    logic         d1_cfg_v_i, d1_cfg_ready_o, d1_cfg_done_o;

    bsg_manycore_ver_chain_stitch #(.num_nodes_p(N), .width_p(W), .els_p(E)) dut (
        .mc_clk_i(clk), .mc_reset_n_i(rst_n),
        .ext_n_v_i(ext_n_v_i), .ext_n_data_i(ext_n_data_i), .ext_n_ready_o(ext_n_ready_o),
        .ext_s_v_o(ext_s_v_o), .ext_s_data_o(ext_s_data_o), .ext_s_ready_i(ext_s_ready_i),
        .ext_s_v_i(ext_s_v_i), .ext_s_data_i(ext_s_data_i), .ext_s_ready_o(ext_s_ready_o),
        .ext_n_v_o(ext_n_v_o), .ext_n_data_o(ext_n_data_o), .ext_n_ready_i(ext_n_ready_i),
        .node_sb_v_o(node_sb_v_o), .node_sb_data_o(node_sb_data_o), .node_sb_ready_i(node_sb_ready_i),
        .node_sb_v_i(node_sb_v_i), .node_sb_data_i(node_sb_data_i), .node_sb_ready_o(node_sb_ready_o),
        .node_nb_v_o(node_nb_v_o), .node_nb_data_o(node_nb_data_o), .node_nb_ready_i(node_nb_ready_i),
        .node_nb_v_i(node_nb_v_i), .node_nb_data_i(node_nb_data_i), .node_nb_ready_o(node_nb_ready_o),
        .node_idle_i(node_idle_i),
        .cfg_v_i(cfg_v_i), .cfg_bypass_i(cfg_bypass_i), .cfg_ready_o(cfg_ready_o),
        .cfg_done_o(cfg_done_o), .bypass_o(bypass_o)
    );

    bsg_manycore_ver_chain_stitch #(.num_nodes_p(1), .width_p(W), .els_p(E)) dut1 (
        .mc_clk_i(clk), .mc_reset_n_i(rst_n),
        .ext_n_v_i(d1_ext_n_v_i), .ext_n_data_i(d1_ext_n_data_i), .ext_n_ready_o(d1_ext_n_ready_o),
        .ext_s_v_o(d1_ext_s_v_o), .ext_s_data_o(d1_ext_s_data_o), .ext_s_ready_i(d1_ext_s_ready_i),
        .ext_s_v_i(d1_ext_s_v_i), .ext_s_data_i(d1_ext_s_data_i), .ext_s_ready_o(d1_ext_s_ready_o),
        .ext_n_v_o(d1_ext_n_v_o), .ext_n_data_o(d1_ext_n_data_o), .ext_n_ready_i(d1_ext_n_ready_i),
        .node_sb_v_o(d1_node_sb_v_o), .node_sb_data_o(d1_node_sb_data_o), .node_sb_ready_i(1'b1),
        .node_sb_v_i(1'b0), .node_sb_data_i('0), .node_sb_ready_o(d1_node_sb_ready_o),
        .node_nb_v_o(d1_node_nb_v_o), .node_nb_data_o(d1_node_nb_data_o), .node_nb_ready_i(1'b1),
        .node_nb_v_i(1'b0), .node_nb_data_i('0), .node_nb_ready_o(d1_node_nb_ready_o),
        .node_idle_i(1'b1),
        .cfg_v_i(d1_cfg_v_i), .cfg_bypass_i(d1_cfg_bypass_i), .cfg_ready_o(d1_cfg_ready_o),
        .cfg_done_o(d1_cfg_done_o), .bypass_o(d1_bypass_o)
    );

    // Node stubs: single-entry echo buffers that forward each word one cycle later.
    logic [N-1:0]        sb_full, nb_full;
    logic [N-1:0][W-1:0] sb_buf, nb_buf;
    int                  nb_pass [N];

    assign node_sb_ready_i = ~sb_full;
    assign node_sb_v_i     = sb_full;
    assign node_sb_data_i  = sb_buf;
    assign node_nb_ready_i = ~nb_full;
    assign node_nb_v_i     = nb_full;
    assign node_nb_data_i  = nb_buf;
    assign node_idle_i     = ~(sb_full | nb_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_full <= '0;
            nb_full <= '0;
            for (int i = 0; i < N; i++) nb_pass[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sb_full[i] && node_sb_ready_o[i]) sb_full[i] <= 1'b0;
                else if (node_sb_v_o[i] && !sb_full[i]) begin
                    sb_full[i] <= 1'b1;
                    sb_buf[i]  <= node_sb_data_o[i*W +: W];
                end
                if (nb_full[i] && node_nb_ready_o[i]) nb_full[i] <= 1'b0;
                else if (node_nb_v_o[i] && !nb_full[i]) begin
                    nb_full[i]  <= 1'b1;
                    nb_buf[i]   <= node_nb_data_o[i*W +: W];
                    nb_pass[i]  <= nb_pass[i] + 1;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    int leak = 0;
    logic [W-1:0] sent_s[$], got_s[$], sent_n[$], got_n[$];
    int           sent_st[$], got_st[$], sent_nt[$], got_nt[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Records the handshakes that will complete at the coming rising edge, then advances to the next falling edge.
    task automatic cyc();
        #1;
        if (ext_n_v_i && ext_n_ready_o) begin sent_s.push_back(ext_n_data_i); sent_st.push_back(cyc_cnt); end
        if (ext_s_v_i && ext_s_ready_o) begin sent_n.push_back(ext_s_data_i); sent_nt.push_back(cyc_cnt); end
        if (ext_s_v_o && ext_s_ready_i) begin got_s.push_back(ext_s_data_o); got_st.push_back(cyc_cnt); end
        if (ext_n_v_o && ext_n_ready_i) begin got_n.push_back(ext_n_data_o); got_nt.push_back(cyc_cnt); end
        if (cfg_done_o) done_cnt++;
        cyc_cnt++;
        @(negedge clk);
    endtask

    task automatic clr();
        sent_s.delete(); got_s.delete(); sent_n.delete(); got_n.delete();
        sent_st.delete(); got_st.delete(); sent_nt.delete(); got_nt.delete();
    endtask

    task automatic cfg_run(input logic [N-1:0] m);
        cfg_v_i = 1'b1;
        cfg_bypass_i = m;
        cyc();
        cfg_v_i = 1'b0;
        for (int i = 0; i < 50 && cfg_done_o !== 1'b1; i++) cyc();
        chk("cfg_done_seen", cfg_done_o, 1);
        cyc();
        chk("cfg_mask_applied", bypass_o, m);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_sb_count"}, got_s.size(), sent_s.size());
        for (int i = 0; i < sent_s.size() && i < got_s.size(); i++)
            chk({tag, "_sb_word"}, got_s[i], sent_s[i]);
        chk({tag, "_nb_count"}, got_n.size(), sent_n.size());
        for (int i = 0; i < sent_n.size() && i < got_n.size(); i++)
            chk({tag, "_nb_word"}, got_n[i], sent_n[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        ext_n_v_i = 0; ext_n_data_i = '0; ext_s_ready_i = 1;
        ext_s_v_i = 0; ext_s_data_i = '0; ext_n_ready_i = 1;
        cfg_v_i = 0; cfg_bypass_i = '0;
        d1_ext_n_v_i = 0; d1_ext_n_data_i = '0; d1_ext_s_ready_i = 1;
        d1_ext_s_v_i = 0; d1_ext_s_data_i = '0; d1_ext_n_ready_i = 1;
        d1_cfg_v_i = 0; d1_cfg_bypass_i = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_bypass", bypass_o, 0);
        chk("rst_ext_s_v", ext_s_v_o, 0);
        chk("rst_ext_n_v", ext_n_v_o, 0);
        chk("rst_node_sb_v", node_sb_v_o, 0);
        chk("rst_node_nb_v", node_nb_v_o, 0);
        chk("rst_cfg_ready", cfg_ready_o, 1);
        chk("rst_cfg_done", cfg_done_o, 0);
        chk("rst_ext_n_ready", ext_n_ready_o, 1);
        chk("rst_ext_s_ready", ext_s_ready_o, 1);
        @(negedge clk);

        // Empty-chain reconfiguration: one DRAIN cycle, one APPLY cycle, then the mask is live.
        cfg_v_i = 1'b1; cfg_bypass_i = 2'b11;
        cyc();
        cfg_v_i = 1'b0;
        chk("drain_cfg_ready", cfg_ready_o, 0);
        chk("drain_ext_n_ready", ext_n_ready_o, 0);
        chk("drain_ext_s_ready", ext_s_ready_o, 0);
        chk("drain_done", cfg_done_o, 0);
        cyc();
        chk("apply_done", cfg_done_o, 1);
        chk("apply_bypass_old", bypass_o, 0);
        chk("apply_ext_n_ready", ext_n_ready_o, 0);
        cyc();
        chk("idle_done_low", cfg_done_o, 0);
        chk("idle_bypass_11", bypass_o, 2'b11);
        chk("idle_ext_n_ready", ext_n_ready_o, 1);

        // All-bypass latency n+1 = 3.
        ext_n_v_i = 1'b1; ext_n_data_i = 16'h00A5;
        cyc();
        ext_n_v_i = 1'b0;
        chk("lat_t1_v", ext_s_v_o, 0);
        cyc();
        chk("lat_t2_v", ext_s_v_o, 0);
        cyc();
        chk("lat_t3_v", ext_s_v_o, 1);
        chk("lat_t3_data", ext_s_data_o, 16'h00A5);
        cyc();

        clr();
        for (int i = 1; i <= 8; i++) begin
            ext_n_v_i = 1'b1; ext_n_data_i = W'(i);
            cyc();
        end
        ext_n_v_i = 1'b0;
        repeat (8) cyc();
        chk("burst_accepted", sent_s.size(), 8);
        chk("burst_count", got_s.size(), 8);
        for (int i = 0; i < 8 && i < got_s.size(); i++) begin
            chk("burst_word", got_s[i], W'(i + 1));
            chk("burst_no_gap", got_st[i] - got_st[0], i);
        end
        chk("burst_latency", (got_st.size() > 0) ? got_st[0] - sent_st[0] : -1, 3);

        // Backpressure: three 2-deep segments hold exactly six words.
        clr();
        ext_s_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ext_n_v_i = 1'b1; ext_n_data_i = W'(16'h100 + sent_s.size());
            cyc();
        end
        ext_n_v_i = 1'b0;
        chk("bp_accepted", sent_s.size(), 6);
        chk("bp_ready_low", ext_n_ready_o, 0);
        ext_s_ready_i = 1'b1;
        repeat (10) cyc();
        cmp_stream("bp");

        // Active nodes through echo stubs: northbound passes node 1 then node 0.
        cfg_run(2'b00);
        clr();
        ext_s_v_i = 1'b1; ext_s_data_i = 16'h0011;
        cyc();
        ext_s_v_i = 1'b0;
        repeat (10) cyc();
        chk("echo_count", got_n.size(), 1);
        chk("echo_data", (got_n.size() > 0) ? got_n[0] : 16'hFFFF, 16'h0011);
        chk("echo_latency", (got_nt.size() > 0) ? got_nt[0] - sent_nt[0] : -1, 5);
        chk("echo_node1_pass", nb_pass[1], 1);
        chk("echo_node0_pass", nb_pass[0], 1);

        // Reconfigure to 2'b01 while both directions stream.
        clr();
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            ext_n_v_i = 1'b1; ext_n_data_i = W'(16'h200 + sent_s.size());
            ext_s_v_i = 1'b1; ext_s_data_i = W'(16'h300 + sent_n.size());
            cyc();
        end
        ext_n_data_i = W'(16'h200 + sent_s.size());
        ext_s_data_i = W'(16'h300 + sent_n.size());
        cfg_v_i = 1'b1; cfg_bypass_i = 2'b01;
        cyc();
        cfg_v_i = 1'b0;
        chk("load_n_ready_drop", ext_n_ready_o, 0);
        chk("load_s_ready_drop", ext_s_ready_o, 0);
        for (int i = 0; i < 200 && cfg_done_o !== 1'b1; i++) begin
            ext_n_data_i = W'(16'h200 + sent_s.size());
            ext_s_data_i = W'(16'h300 + sent_n.size());
            if (ext_n_ready_o || ext_s_ready_o) leak++;
            cyc();
        end
        chk("load_done_seen", cfg_done_o, 1);
        chk("load_no_ingress_leak", leak, 0);
        chk("load_apply_nodes_idle", node_idle_i, 2'b11);
        chk("load_apply_s_empty", ext_s_v_o, 0);
        chk("load_apply_n_empty", ext_n_v_o, 0);
        cyc();
        chk("load_bypass_01", bypass_o, 2'b01);
        chk("load_ingress_reopen", ext_n_ready_o, 1);
        for (int i = 0; i < 6; i++) begin
            ext_n_data_i = W'(16'h200 + sent_s.size());
            ext_s_data_i = W'(16'h300 + sent_n.size());
            cyc();
        end
        ext_n_v_i = 1'b0; ext_s_v_i = 1'b0;
        repeat (40) cyc();
        chk("load_done_once", done_cnt, 1);
        cmp_stream("load");

        // Reset while stuck in DRAIN discards both the pending mask and buffered words.
        clr();
        ext_s_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ext_n_v_i = 1'b1; ext_n_data_i = W'(16'h400 + sent_s.size());
            cyc();
        end
        ext_n_v_i = 1'b0;
        cfg_v_i = 1'b1; cfg_bypass_i = 2'b10;
        cyc();
        cfg_v_i = 1'b0;
        chk("mid_drain_busy", cfg_ready_o, 0);
        repeat (3) cyc();
        chk("mid_drain_stuck", cfg_done_o, 0);
        chk("mid_drain_s_full", ext_s_v_o, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_v", ext_s_v_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_bypass", bypass_o, 0);
        chk("post_rst_cfg_ready", cfg_ready_o, 1);
        chk("post_rst_ext_n_ready", ext_n_ready_o, 1);
        chk("post_rst_ext_n_v", ext_n_v_o, 0);
        @(negedge clk);
        clr();
        done_cnt = 0;
        ext_s_ready_i = 1'b1;
        repeat (8) cyc();
        chk("post_rst_no_data", got_s.size() + got_n.size(), 0);
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_bypass_hold", bypass_o, 0);

        // Single-node column, bypassed: latency 2 each direction.
        d1_cfg_v_i = 1'b1; d1_cfg_bypass_i = 1'b1;
        cyc();
        d1_cfg_v_i = 1'b0;
        for (int i = 0; i < 20 && d1_cfg_done_o !== 1'b1; i++) cyc();
        chk("n1_done_seen", d1_cfg_done_o, 1);
        cyc();
        chk("n1_bypass", d1_bypass_o, 1);
        d1_ext_n_v_i = 1'b1; d1_ext_n_data_i = 16'h005A;
        d1_ext_s_v_i = 1'b1; d1_ext_s_data_i = 16'h003C;
        chk("n1_ready_n", d1_ext_n_ready_o, 1);
        cyc();
        d1_ext_n_v_i = 1'b0; d1_ext_s_v_i = 1'b0;
        chk("n1_t1_s_v", d1_ext_s_v_o, 0);
        chk("n1_t1_n_v", d1_ext_n_v_o, 0);
        cyc();
        chk("n1_t2_s_v", d1_ext_s_v_o, 1);
        chk("n1_t2_s_data", d1_ext_s_data_o, 16'h005A);
        chk("n1_t2_n_v", d1_ext_n_v_o, 1);
        chk("n1_t2_n_data", d1_ext_n_data_o, 16'h003C);
        cyc();
        chk("n1_t3_s_v", d1_ext_s_v_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bsg_manycore_ver_chain_stitch.md
# bsg_manycore_ver_chain_stitch

Parametrised vertical stitch for a column of `num_nodes_p` tile nodes in a BlackParrot pod on the manycore clock. It carries two valid/ready streams through every node in a daisy chain:

- southbound: external N → node 0 → … → node n-1 → external S
- northbound: the reverse path

Every hop is buffered by a FIFO. Any node can be bypassed at runtime through a drain-safe reconfiguration handshake. This replaces fixed, hard-wired two-node stitching with registered, elastic, reconfigurable stitching.

## Interface
Parameters:
- `num_nodes_p`, default 2: nodes in the column (≥1). The chain has `num_nodes_p+1` segments per direction.
- `width_p`, default 64: payload width per stream.
- `els_p`, default 2: FIFO depth per segment (power of two, ≥2).

Ports (n = `num_nodes_p`, w = `width_p`):
- `mc_clk_i`  in  1  the single clock.
- `mc_reset_n_i`  in  1  asynchronous, active-low reset.
- `ext_n_v_i` / `ext_n_data_i` / `ext_n_ready_o`  in/in/out  1/w/1  southbound ingress from the north.
- `ext_s_v_o` / `ext_s_data_o` / `ext_s_ready_i`  out/out/in  1/w/1  southbound egress to the south.
- `ext_s_v_i` / `ext_s_data_i` / `ext_s_ready_o`  in/in/out  1/w/1  northbound ingress from the south.
- `ext_n_v_o` / `ext_n_data_o` / `ext_n_ready_i`  out/out/in  1/w/1  northbound egress to the north.
- `node_sb_v_o` / `node_sb_data_o` / `node_sb_ready_i`  out/out/in  n/n×w/n  southbound delivery into node i.
- `node_sb_v_i` / `node_sb_data_i` / `node_sb_ready_o`  in/in/out  n/n×w/n  southbound output from node i.
- `node_nb_v_o` / `node_nb_data_o` / `node_nb_ready_i`  out/out/in  n/n×w/n  northbound delivery into node i.
- `node_nb_v_i` / `node_nb_data_i` / `node_nb_ready_o`  in/in/out  n/n×w/n  northbound output from node i.
- `node_idle_i`  in  n  node i holds no in-flight traffic.
- `cfg_v_i` / `cfg_bypass_i` / `cfg_ready_o`  in/in/out  1/n/1  reconfiguration request.
- `cfg_done_o`  out  1  one-cycle pulse when a new mask is applied.
- `bypass_o`  out  n  active bypass mask.

## Operation
Segment mapping:
- Southbound segment k is fed by ext N ingress when k=0, otherwise by node k-1 output. It feeds node k when k<n, otherwise ext S egress.
- Northbound segment k is fed by ext S ingress when k=n, otherwise by node k output. It feeds node k-1 when k≥1, otherwise ext N egress.

Segment FIFOs:
- Each FIFO has `els_p` entries, registered output, no fall-through.
- Its upstream ready is `!full`. Enqueue and dequeue may happen in the same cycle.

Bypass of node i (`bypass_o[i]`=1):
- Node i's `*_v_o` and `*_ready_o` are 0 and its `*_v_i` are ignored.
- The dequeue side of the FIFO that would feed node i connects combinationally to the enqueue side of the FIFO that node i would feed, in each direction.
- Consecutive bypassed nodes chain combinationally.

Reconfiguration FSM:
- IDLE: `cfg_ready_o`=1. On `cfg_v_i`, latch `cfg_bypass_i` → DRAIN.
- DRAIN: `ext_n_ready_o` and `ext_s_ready_o` are forced to 0; all other flow is unchanged. Leave for APPLY when every FIFO is empty and `node_idle_i` is all ones.
- APPLY, one cycle: `bypass_r` ← pending mask, `cfg_done_o`=1 → IDLE.
- Any mask is legal, including all-ones (pure buffered wire) and all-zeros.
- A request whose mask equals the current mask still runs the full drain.

Handshake rules:
- Data transfers when v & ready.
- A valid must not depend on the same interface's ready.
- Once asserted, a valid holds until the transfer completes.

Reset values:
- FSM in IDLE and all FIFOs empty.
- `bypass_o`=0, `cfg_done_o`=0, `cfg_ready_o`=1.
- All `*_v_o`=0.
- Ingress readies=1 once reset deasserts.
- Asserting reset mid-DRAIN discards the pending mask and all buffered data.

## Timing
- Each segment adds exactly 1 cycle. A word accepted at ext N in cycle t with all nodes bypassed appears at `ext_s_v_o` in cycle t+n+1. Throughput is 1 word/cycle per direction.
- DRAIN lasts at least 1 cycle, even when the chain is already empty. APPLY follows the first cycle in which the drain condition holds.
- The new mask takes effect in the cycle after APPLY. External ingress reopens in that same cycle.
- `cfg_done_o` is high in the APPLY cycle only.

## Test plan
- Reset: hold `mc_reset_n_i`=0 for 3 cycles, then release → `bypass_o`=0, all `*_v_o`=0, `cfg_ready_o`=1, `ext_*_ready_o`=1.
- Bypassed pipeline, n=2, mask 2'b11: push 0xA5 at ext N in cycle 10 → `ext_s_v_o`=1 with data 0xA5 in cycle 13. Also check that words 1..8 arrive in order with no gaps.
- Backpressure, n=2, `els_p`=2, mask 2'b11, `ext_s_ready_i`=0: stream at ext N → exactly 6 words accepted, then `ext_n_ready_o`=0. Release → 6 words out in order.
- Active nodes, n=2, mask 0, nodes as 1-cycle echo stubs: send 0x11 northbound from ext S → it arrives at `ext_n_data_o` after passing node 1 then node 0, with no duplication or loss.
- Reconfigure under load: stream both directions, request mask 2'b01 → ingress readies drop, FSM waits for FIFOs empty and `node_idle_i`=2'b11. `cfg_done_o` pulses once, `bypass_o`=2'b01, and every accepted word is delivered exactly once.
- Reset mid-DRAIN plus n=1: assert reset during DRAIN → `bypass_o` stays 0 and the FIFOs are empty. With n=1, mask 1'b1 → latency is 2 cycles.
